keypad_scan_4x4: RTL

- Front-end input stage for the coffer lock. Scans a 4x4 matrix keypad, debounces it, and emits one registered key code per press with a one-cycle valid pulse.
- Replaces the slide-switch plus separate-key input path.
- The downstream lock controller consumes key_code/key_valid directly: digits 0-9, codes 10-15 for function keys (confirm, clear, etc.).

---
 rtl/keypad_pkg.sv | 60 ++++++
 rtl/keypad_scan_4x4_if.sv | 20 ++
 rtl/keypad_col_driver.sv | 55 +++++
 rtl/keypad_scan_4x4.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
// Holds the debounce FSM states, the snapshot classification and the key code map.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CANDIDATE,
        PRESSED,
        RELEASE
    } kp_state_e;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_SINGLE,
        CLS_MULTI
    } snap_cls_e;

    typedef struct packed {
        snap_cls_e  cls;
        logic [3:0] idx;   // meaningful only when cls == CLS_SINGLE
    } snap_info_t;

    localparam logic [3:0] KEY_0       = 4'd0;
    localparam logic [3:0] KEY_1       = 4'd1;
    localparam logic [3:0] KEY_2       = 4'd2;
    localparam logic [3:0] KEY_3       = 4'd3;
    localparam logic [3:0] KEY_4       = 4'd4;
    localparam logic [3:0] KEY_5       = 4'd5;
    localparam logic [3:0] KEY_6       = 4'd6;
    localparam logic [3:0] KEY_7       = 4'd7;
    localparam logic [3:0] KEY_8       = 4'd8;
    localparam logic [3:0] KEY_9       = 4'd9;
    localparam logic [3:0] KEY_CONFIRM = 4'd10;
    localparam logic [3:0] KEY_CLEAR   = 4'd11;
    localparam logic [3:0] KEY_SET     = 4'd12;

    // Column drive after reset: column 0 pulled low first.
    localparam logic [3:0] COL_RST = 4'b1110;

    // Classify a full-scan snapshot (bit = key down, index = row*4 + col).
    function automatic snap_info_t classify(input logic [15:0] snap);
        snap_info_t  info;
        int unsigned n_down;
        info.cls = CLS_NONE;
        info.idx = 4'd0;
        n_down   = 0;
        for (int i = 0; i < 16; i++) begin
            if (snap[i]) begin
                n_down++;
                info.idx = 4'(i);
            end
        end
        if (n_down == 1)
            info.cls = CLS_SINGLE;
        else if (n_down > 1)
            info.cls = CLS_MULTI;
        return info;
    endfunction

endpackage

// File: rtl/keypad_scan_4x4_if.sv
// keypad_scan_4x4_if: keypad matrix pins plus the key-event bus to the lock controller.
// master = scanner side, slave = keypad model / consumer side.
interface keypad_scan_4x4_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       multi_key;

    modport master (
        input  row_in,
        output col_out, key_code, key_valid, key_held, multi_key
    );

    modport slave (
        output row_in,
        input  col_out, key_code, key_valid, key_held, multi_key
    );
endinterface

// File: rtl/keypad_col_driver.sv
// keypad_col_driver: column rotation timebase. Each column is driven low for
// SCAN_DIV clocks; the last clock of each column is the row sample strobe, and
// the sample of column 3 is the full-scan boundary.
module keypad_col_driver
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] col_out_o,
    output logic [1:0] col_idx_o,
    output logic       sample_o,
    output logic       boundary_o
);
    localparam int             DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       col_q, col_d;

    assign sample_o   = (div_q == DIV_LAST);
    assign boundary_o = sample_o && (col_idx_q == 2'd3);
    assign col_out_o  = col_q;
    assign col_idx_o  = col_idx_q;

    // Next-state: advance divider, rotate to the next column on terminal count.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        div_d     = div_q + DIV_W'(1);
        col_idx_d = col_idx_q;
        col_d     = col_q;
        if (sample_o) begin
            div_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            col_d     = {col_q[2:0], col_q[3]};
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            div_q     <= '0;
            col_idx_q <= 2'd0;
            col_q     <= COL_RST;
        end else begin
            div_q     <= div_d;
            col_idx_q <= col_idx_d;
            col_q     <= col_d;
        end
    end

endmodule

// File: rtl/keypad_scan_4x4.sv
// keypad_scan_4x4: 4x4 matrix keypad front end for the coffer lock. Synchronises
// the rows, builds a per-scan snapshot, classifies it and debounces one key into a
// registered key_code with a one-clock key_valid pulse.
// Optional build macro KEYPAD_REPEAT_EN: auto-repeat key_valid while a key stays held.
module keypad_scan_4x4
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV           = 1000,
    parameter int DEBOUNCE_SCANS     = 3,
    parameter int REPEAT_DELAY_SCANS = 64,
    parameter int REPEAT_RATE_SCANS  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    keypad_scan_4x4_if.master kp
);
    localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

    logic [3:0]  col_out;
    logic [1:0]  col_idx;
    logic        sample, boundary;

    logic [3:0]  row_meta_q, row_sync_q;
    logic [15:0] snap_q, snap_cur;
    snap_info_t  info;
    logic        is_single, still_down;

    kp_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  cand_q, cand_d;
    logic [3:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic        held_q, held_d;
    logic        multi_q, multi_d;
    logic        accept;
    logic [3:0]  accept_code;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = 16;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_first_q, rep_first_d;
`else
    logic unused_repeat_params;
    assign unused_repeat_params = ^{32'(REPEAT_DELAY_SCANS), 32'(REPEAT_RATE_SCANS)};
`endif

    keypad_col_driver #(.SCAN_DIV(SCAN_DIV)) u_col_driver (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_out_o (col_out),
        .col_idx_o (col_idx),
        .sample_o  (sample),
        .boundary_o(boundary)
    );

    // Merge the column being sampled into the snapshot so the boundary sees column 3 too.
    always_comb begin
        snap_cur = snap_q;
        for (int r = 0; r < 4; r++)
            snap_cur[r*4 + int'(col_idx)] = ~row_sync_q[r];
    end

    assign info       = classify(snap_cur);
    assign is_single  = (info.cls == CLS_SINGLE);
    assign still_down = (is_single && info.idx == code_q) || (info.cls == CLS_MULTI);

    // Row synchroniser and snapshot capture.
    always_ff @(posedge clk) begin
        // NOTE: the 16-bit snapshot is reset too; it is plain flops, and a stale snapshot would leak a pre-reset key into the first scan.
        if (!rst_n) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            snap_q     <= '0;
        end else begin
            row_meta_q <= kp.row_in;
            row_sync_q <= row_meta_q;
            if (sample)
                snap_q <= snap_cur;
        end
    end

    // Debounce FSM next-state and outputs; only scan boundaries move it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        code_d      = code_q;
        valid_d     = 1'b0;
        held_d      = held_q;
        multi_d     = multi_q;
        accept      = 1'b0;
        accept_code = cand_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
`endif
        if (boundary) begin
            multi_d = (info.cls == CLS_MULTI);
            unique case (state_q)
                IDLE: begin
                    if (is_single) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            accept      = 1'b1;
                            accept_code = info.idx;
                        end else begin
                            state_d = CANDIDATE;
                            cand_d  = info.idx;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                CANDIDATE: begin
                    if (is_single && info.idx == cand_q) begin
                        if (cnt_q + 4'd1 >= DEB)
                            accept = 1'b1;
                        else
                            cnt_d = cnt_q + 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                PRESSED: begin
                    if (still_down) begin
`ifdef KEYPAD_REPEAT_EN
                        rep_d = rep_q + REP_W'(1);
                        if (rep_d == (rep_first_q ? REP_W'(REPEAT_RATE_SCANS)
                                                  : REP_W'(REPEAT_DELAY_SCANS))) begin
                            valid_d     = 1'b1;
                            rep_d       = '0;
                            rep_first_d = 1'b1;
                        end
`endif
                    end else if (DEBOUNCE_SCANS == 1) begin
                        held_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = RELEASE;
                        cnt_d   = 4'd1;
                    end
                end
                RELEASE: begin
                    if (info.cls == CLS_NONE) begin
                        if (cnt_q + 4'd1 >= DEB) begin
                            held_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (still_down) begin
                        state_d = PRESSED;
                    end
                end
            endcase
            if (accept) begin
                code_d  = accept_code;
                valid_d = 1'b1;
                held_d  = 1'b1;
                state_d = PRESSED;
`ifdef KEYPAD_REPEAT_EN
                rep_d       = '0;
                rep_first_d = 1'b0;
`endif
            end
        end
    end

    // Debounce FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            cand_q  <= 4'd0;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            multi_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
            rep_first_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
            multi_q <= multi_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
`endif
        end
    end

    assign kp.col_out   = col_out;
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = held_q;
    assign kp.multi_key = multi_q;

endmodule
